ram4_bank: RTL and testbench

- Four-word register bank that sits directly downstream of the 1-to-4 demux.
- Consumes the demux's 4-bit one-hot `out` as a per-word load vector, and writes the shared data input into the selected word on the clock edge.
- Provides a combinational read port, per-word valid tracking, a sticky illegal-load error, and a saturating write counter for debug.
- It is the first sequential storage stage of the memory hierarchy (RAM4 building block).

---
 rtl/ram4_bank.sv | 118 +++++++++++
 tb/tb_ram4_bank.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram4_bank.sv
// ----------------------------------------------------------------------------
// ram4_bank
//
// Four-word register bank that sits directly behind the 1-to-4 demux. The
// demux's one-hot output arrives as load_vec and selects which word captures
// the shared write data on the rising clock edge.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   load_vec  in   [3:0]        per-word load strobes, bit i loads word i
//   in        in   [WIDTH-1:0]  write data shared by all four words
//   addr      in   [1:0]        read address
//   err_clr   in   synchronous clear of the sticky error flag
//   out       out  [WIDTH-1:0]  word[addr], combinational
//   rd_valid  out  valid[addr], combinational
//   valid     out  [3:0]        per-word "written since reset" flags
//   err       out  sticky flag, set when a multi-hot load_vec is seen
//   wr_count  out  [CNT_W-1:0]  successful writes since reset, saturating
// ----------------------------------------------------------------------------
module ram4_bank #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       load_vec,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       addr,
    input  logic             err_clr,
    output logic [WIDTH-1:0] out,
    output logic             rd_valid,
    output logic [3:0]       valid,
    output logic             err,
    output logic [CNT_W-1:0] wr_count
);

    logic [WIDTH-1:0] word_q [4];
    logic [WIDTH-1:0] word_d [4];
    logic [3:0]       valid_q;
    logic [3:0]       valid_d;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic             lv_zero;
    logic             lv_onehot;
    logic             lv_illegal;

    // Clearing the lowest set bit leaves zero only when at most one bit was
    // set, so a non-zero vector passing that test is exactly one-hot.
    always_comb begin
        lv_zero    = (load_vec == 4'b0000);
        lv_onehot  = !lv_zero && ((load_vec & (load_vec - 4'd1)) == 4'b0000);
        lv_illegal = !lv_zero && !lv_onehot;
    end

    // Next-state logic. A one-hot vector writes its word, marks it valid and
    // bumps the counter (holding at all-ones). An illegal vector touches only
    // err; because the set is applied after the clear, set wins when both
    // happen on the same edge.
    always_comb begin
        word_d  = word_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        if (lv_onehot) begin
            for (int i = 0; i < 4; i++) begin
                if (load_vec[i]) begin
                    word_d[i]  = in;
                    valid_d[i] = 1'b1;
                end
            end
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (err_clr) begin
            err_d = 1'b0;
        end
        if (lv_illegal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                word_q[i] <= '0;
            end
            valid_q <= 4'b0000;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                word_q[i] <= word_d[i];
            end
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read port has no latency and no write bypass: it always shows the
    // currently registered contents.
    always_comb begin
        out      = word_q[addr];
        rd_valid = valid_q[addr];
    end

    assign valid    = valid_q;
    assign err      = err_q;
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_ram4_bank.sv
// ----------------------------------------------------------------------------
// tb_ram4_bank
//
// Directed testbench for ram4_bank. Inputs change on the falling edge, outputs
// are sampled 1 ns after the rising edge or on the falling edge.
// ----------------------------------------------------------------------------
module tb_ram4_bank;

    logic        clk;
    logic        rst;
    logic [3:0]  load_vec;
    logic [15:0] in;
    logic [1:0]  addr;
    logic        err_clr;
    logic [15:0] out;
    logic        rd_valid;
    logic [3:0]  valid;
    logic        err;
    logic [7:0]  wr_count;

    int checks;
    int errors;

    ram4_bank #(.WIDTH(16), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .load_vec (load_vec),
        .in       (in),
        .addr     (addr),
        .err_clr  (err_clr),
        .out      (out),
        .rd_valid (rd_valid),
        .valid    (valid),
        .err      (err),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one edge's worth of load/clear inputs, then returns just after
    // the rising edge with the inputs back to idle.
    task automatic drive_edge(input logic [3:0] lv, input logic [15:0] data,
                              input logic clr);
        @(negedge clk);
        load_vec = lv;
        in       = data;
        err_clr  = clr;
        @(posedge clk);
        #1;
        load_vec = 4'b0000;
        err_clr  = 1'b0;
    endtask

    task automatic test_reset();
        // Dirty the bank first so reset has something to clear.
        drive_edge(4'b0001, 16'hAAAA, 1'b0);
        drive_edge(4'b1000, 16'h5555, 1'b0);
        drive_edge(4'b0110, 16'h0000, 1'b0);
        checks++;
        if (wr_count !== 8'd2 || err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset: wr_count=%0d err=%b, required 2/1", wr_count, err);
        end
        // Assert reset mid-cycle and look before any clock edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (valid !== 4'b0000 || err !== 1'b0 || wr_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_async: valid=%b err=%b wr_count=%0d, required 0000/0/0",
                     valid, err, wr_count);
        end
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0];
            #1;
            checks++;
            if (out !== 16'h0000 || rd_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_read%0d: out=%h rd_valid=%b, required 0000/0",
                         a, out, rd_valid);
            end
        end
        // A load attempted while reset is held must not land.
        load_vec = 4'b0001;
        in       = 16'h9999;
        @(posedge clk);
        #1;
        addr = 2'd0;
        #1;
        checks++;
        if (out !== 16'h0000 || wr_count !== 8'd0 || valid !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_hold: out=%h wr_count=%0d valid=%b, required 0000/0/0000",
                     out, wr_count, valid);
        end
        @(negedge clk);
        load_vec = 4'b0000;
        rst      = 1'b0;
    endtask

    task automatic test_onehot();
        logic [15:0] exp_words [4];
        exp_words[0] = 16'h1111;
        exp_words[1] = 16'h2222;
        exp_words[2] = 16'h3333;
        exp_words[3] = 16'h4444;
        drive_edge(4'b0001, 16'h1111, 1'b0);
        drive_edge(4'b0010, 16'h2222, 1'b0);
        drive_edge(4'b0100, 16'h3333, 1'b0);
        drive_edge(4'b1000, 16'h4444, 1'b0);
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0];
            #1;
            checks++;
            if (out !== exp_words[a] || rd_valid !== 1'b1) begin
                errors++;
                $display("[TB] FAIL onehot_read%0d: out=%h rd_valid=%b, required %h/1",
                         a, out, rd_valid, exp_words[a]);
            end
        end
        checks++;
        if (valid !== 4'b1111 || wr_count !== 8'd4 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL onehot_state: valid=%b wr_count=%0d err=%b, required 1111/4/0",
                     valid, wr_count, err);
        end
    endtask

    task automatic test_illegal();
        drive_edge(4'b0110, 16'hDEAD, 1'b0);
        checks++;
        if (err !== 1'b1 || wr_count !== 8'd4) begin
            errors++;
            $display("[TB] FAIL illegal_err: err=%b wr_count=%0d, required 1/4", err, wr_count);
        end
        addr = 2'd1;
        #1;
        checks++;
        if (out !== 16'h2222) begin
            errors++;
            $display("[TB] FAIL illegal_word1: out=%h, required 2222", out);
        end
        addr = 2'd2;
        #1;
        checks++;
        if (out !== 16'h3333) begin
            errors++;
            $display("[TB] FAIL illegal_word2: out=%h, required 3333", out);
        end
        drive_edge(4'b0000, 16'h0000, 1'b0);
        drive_edge(4'b0000, 16'h0000, 1'b0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_sticky: err=%b, required 1", err);
        end
        drive_edge(4'b0000, 16'h0000, 1'b1);
        checks++;
        if (err !== 1'b0 || wr_count !== 8'd4 || valid !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL illegal_clear: err=%b wr_count=%0d valid=%b, required 0/4/1111",
                     err, wr_count, valid);
        end
    endtask

    task automatic test_set_beats_clear();
        drive_edge(4'b1111, 16'hCAFE, 1'b1);
        checks++;
        if (err !== 1'b1 || wr_count !== 8'd4) begin
            errors++;
            $display("[TB] FAIL set_beats_clear: err=%b wr_count=%0d, required 1/4", err, wr_count);
        end
        addr = 2'd3;
        #1;
        checks++;
        if (out !== 16'h4444) begin
            errors++;
            $display("[TB] FAIL set_beats_clear_nowrite: out=%h, required 4444", out);
        end
        drive_edge(4'b0000, 16'h0000, 1'b1);
    endtask

    task automatic test_read_during_write();
        @(negedge clk);
        addr     = 2'd2;
        load_vec = 4'b0100;
        in       = 16'hBEEF;
        #1;
        checks++;
        if (out !== 16'h3333) begin
            errors++;
            $display("[TB] FAIL rdw_before: out=%h, required 3333", out);
        end
        @(posedge clk);
        #1;
        load_vec = 4'b0000;
        checks++;
        if (out !== 16'hBEEF || wr_count !== 8'd5 || err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rdw_after: out=%h wr_count=%0d err=%b, required BEEF/5/0",
                     out, wr_count, err);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] lv;
        // Counter starts at 5, so it reaches 255 after the 250th write.
        for (int i = 0; i < 300; i++) begin
            lv = 4'b0001 << (i % 4);
            drive_edge(lv, i[15:0], 1'b0);
            if (i == 248) begin
                checks++;
                if (wr_count !== 8'd254) begin
                    errors++;
                    $display("[TB] FAIL sat_254: wr_count=%0d, required 254", wr_count);
                end
            end
            if (i == 249) begin
                checks++;
                if (wr_count !== 8'd255) begin
                    errors++;
                    $display("[TB] FAIL sat_255: wr_count=%0d, required 255", wr_count);
                end
            end
        end
        checks++;
        if (wr_count !== 8'd255 || valid !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL sat_hold: wr_count=%0d valid=%b, required 255/1111", wr_count, valid);
        end
        for (int a = 0; a < 4; a++) begin
            addr = a[1:0];
            #1;
            checks++;
            if (out !== 16'(296 + a)) begin
                errors++;
                $display("[TB] FAIL sat_data%0d: out=%h, required %h", a, out, 16'(296 + a));
            end
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        load_vec = 4'b0000;
        in       = 16'h0000;
        addr     = 2'd0;
        err_clr  = 1'b0;
        #1;
        checks++;
        if (out !== 16'h0000 || valid !== 4'b0000 || err !== 1'b0 || wr_count !== 8'd0) begin
            errors++;
            $display("[TB] FAIL power_on_reset: out=%h valid=%b err=%b wr_count=%0d, required 0",
                     out, valid, err, wr_count);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        test_reset();
        test_onehot();
        test_illegal();
        test_set_beats_clear();
        test_read_during_write();
        test_saturation();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
